// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller for a two-operand calculator.
// Debounces keypad presses, builds decimal operands, and issues a request/ack
// handshake to an external ALU.
module calc_entry_ctrl #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  input  logic       calc_ack,
  output logic       calc_req,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [1:0] opcode,
  output logic [7:0] display_val,
  output logic       key_strobe,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    REQ     = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam int           CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE);

  // Debounce state
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic [CW-1:0] low_cnt, low_nxt;
  logic [3:0]    last_value;
  logic [3:0]    key_code;
  logic          armed;

  // Entry state
  state_t     state_q, state_n;
  logic [7:0] op_a_n, op_b_n;
  logic [1:0] opcode_n;
  logic [1:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic       err_n;

  // Key classification of the latched press
  logic        is_digit, is_op, is_clr, is_eq;
  logic [3:0]  op_sel;
  logic [11:0] prod_a, prod_b;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_clr   = (key_code == 4'd14);
  assign is_eq    = (key_code == 4'd15);
  assign op_sel   = key_code - 4'd10;
  assign prod_a   = ({4'b0, op_a} * 12'd10) + {8'b0, key_code};
  assign prod_b   = ({4'b0, op_b} * 12'd10) + {8'b0, key_code};

  // Next hold/low counts: hold restarts on a fresh press or a changed code,
  // both saturate at DEBOUNCE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hold_nxt = '0;
    low_nxt  = '0;
    if (key_valid) begin
      if (hold_cnt == '0 || key_value != last_value) hold_nxt = CW'(1);
      else if (hold_cnt != DB)                        hold_nxt = hold_cnt + 1'b1;
      else                                            hold_nxt = hold_cnt;
    end else begin
      low_nxt = (low_cnt == DB) ? low_cnt : low_cnt + 1'b1;
    end
  end

  // Debounce registers: one strobe per press, re-armed after DEBOUNCE idle cycles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      hold_cnt   <= '0;
      low_cnt    <= '0;
      last_value <= '0;
      key_code   <= '0;
      armed      <= 1'b1;
      key_strobe <= 1'b0;
    end else begin
      hold_cnt   <= hold_nxt;
      low_cnt    <= low_nxt;
      last_value <= key_value;
      key_strobe <= 1'b0;
      if (key_valid && hold_nxt == DB && armed) begin
        key_strobe <= 1'b1;
        key_code   <= key_value;
        armed      <= 1'b0;
      end else if (!key_valid && low_nxt == DB) begin
        armed <= 1'b1;
      end
    end
  end

  // Next-state and operand update; clear overrides everything, including an ack.
  always_comb begin
    state_n  = state_q;
    op_a_n   = op_a;
    op_b_n   = op_b;
    opcode_n = opcode;
    cnt_a_n  = cnt_a;
    cnt_b_n  = cnt_b;
    err_n    = err;

    if (state_q == REQ && calc_ack) state_n = DONE;

    if (key_strobe) begin
      if (is_clr) begin
        state_n  = ENTER_A;
        op_a_n   = '0;
        op_b_n   = '0;
        opcode_n = '0;
        cnt_a_n  = '0;
        cnt_b_n  = '0;
        err_n    = 1'b0;
      end else begin
        unique case (state_q)
          ENTER_A: begin
            if (is_digit) begin
              if (prod_a > 12'd255) err_n = 1'b1;
              else begin
                op_a_n  = prod_a[7:0];
                cnt_a_n = (cnt_a == 2'd3) ? cnt_a : cnt_a + 2'd1;
              end
            end else if (is_op && cnt_a != 2'd0) begin
              opcode_n = op_sel[1:0];
              state_n  = ENTER_B;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              if (prod_b > 12'd255) err_n = 1'b1;
              else begin
                op_b_n  = prod_b[7:0];
                cnt_b_n = (cnt_b == 2'd3) ? cnt_b : cnt_b + 2'd1;
              end
            end else if (is_op && cnt_b == 2'd0) begin
              opcode_n = op_sel[1:0];
            end else if (is_eq && cnt_b != 2'd0) begin
              if (opcode == 2'b11 && op_b == 8'd0) begin
                err_n   = 1'b1;
                state_n = DONE;
              end else begin
                state_n = REQ;
              end
            end
          end
          REQ: ;
          DONE: begin
            if (is_digit) begin
              state_n = ENTER_A;
              op_a_n  = {4'b0, key_code};
              cnt_a_n = 2'd1;
              op_b_n  = '0;
              cnt_b_n = '0;
              err_n   = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      op_a    <= '0;
      op_b    <= '0;
      opcode  <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      op_a    <= op_a_n;
      op_b    <= op_b_n;
      opcode  <= opcode_n;
      cnt_a   <= cnt_a_n;
      cnt_b   <= cnt_b_n;
      err     <= err_n;
    end
  end

  assign state       = state_q;
  assign calc_req    = (state_q == REQ);
  assign display_val = (state_q == ENTER_A) ? op_a : op_b;

endmodule
